// File: rtl/wire_cut_judge.sv
// rtl/wire_cut_judge.sv - judges debounced wire cuts against a latched secret cut order
module wire_cut_judge #(
  parameter int MAX_STRIKES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [5:0]  wire_lvl,
  input  logic [17:0] cut_order,
  input  logic [2:0]  cut_len,
  output logic        step_ok,
  output logic        strike,
  output logic [1:0]  strike_cnt,
  output logic        solved,
  output logic        exploded,
  output logic [2:0]  step_idx
);

  typedef enum logic [1:0] {IDLE, ACTIVE, SOLVED, EXPLODED} state_t;

  localparam logic [1:0] STRIKE_LIMIT = 2'(MAX_STRIKES);

  state_t      state_q, state_d;
  logic [5:0]  prev_lvl;
  logic [17:0] order_q, order_d;
  logic [2:0]  len_q, len_d;
  logic [2:0]  step_idx_d;
  logic [1:0]  strike_cnt_d, cnt_inc;
  logic        step_ok_d, strike_d, solved_d, exploded_d;
  logic [5:0]  cut;
  logic        one_hot;
  logic [2:0]  slot_tbl [8];
  logic [2:0]  exp_slot;
  logic        match;

  assign cut     = prev_lvl & ~wire_lvl;
  assign one_hot = (cut != 6'd0) && ((cut & (cut - 6'd1)) == 6'd0);

  // Entries 6 and 7 are never reached while ACTIVE but keep the lookup total.
  always_comb begin
    for (int k = 0; k < 6; k++) slot_tbl[k] = order_q[3*k +: 3];
    slot_tbl[6] = 3'd7;
    slot_tbl[7] = 3'd7;
  end

  assign exp_slot = slot_tbl[step_idx];
  // Slot values 6 and 7 shift past bit 5 and so can never equal a real cut.
  assign match    = one_hot && ({2'b00, cut} == (8'd1 << exp_slot));
  assign cnt_inc  = (strike_cnt == 2'd3) ? 2'd3 : strike_cnt + 2'd1;

  always_comb begin
    state_d      = state_q;
    order_d      = order_q;
    len_d        = len_q;
    step_idx_d   = step_idx;
    strike_cnt_d = strike_cnt;
    solved_d     = solved;
    exploded_d   = exploded;
    step_ok_d    = 1'b0;
    strike_d     = 1'b0;
    if (arm) begin
      order_d      = cut_order;
      len_d        = (cut_len == 3'd0) ? 3'd1 : (cut_len == 3'd7) ? 3'd6 : cut_len;
      step_idx_d   = 3'd0;
      strike_cnt_d = 2'd0;
      solved_d     = 1'b0;
      exploded_d   = 1'b0;
      state_d      = ACTIVE;
    end else if (state_q == ACTIVE && cut != 6'd0) begin
      if (match) begin
        step_ok_d  = 1'b1;
        step_idx_d = step_idx + 3'd1;
        if (step_idx + 3'd1 == len_q) begin
          solved_d = 1'b1;
          state_d  = SOLVED;
        end
      end else begin
        strike_d     = 1'b1;
        strike_cnt_d = cnt_inc;
        if (cnt_inc == STRIKE_LIMIT) begin
          exploded_d = 1'b1;
          state_d    = EXPLODED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_lvl   <= 6'b111111;
      order_q    <= 18'd0;
      len_q      <= 3'd0;
      step_idx   <= 3'd0;
      strike_cnt <= 2'd0;
      solved     <= 1'b0;
      exploded   <= 1'b0;
      step_ok    <= 1'b0;
      strike     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_lvl   <= wire_lvl;
      order_q    <= order_d;
      len_q      <= len_d;
      step_idx   <= step_idx_d;
      strike_cnt <= strike_cnt_d;
      solved     <= solved_d;
      exploded   <= exploded_d;
      step_ok    <= step_ok_d;
      strike     <= strike_d;
    end
  end

endmodule

// File: doc/wire_cut_judge.md
# wire_cut_judge

Consumes the 6-bit debounced wire levels from the wire input filter and judges each cut against a per-round secret cut order. It emits one-cycle correct-step and strike pulses, counts strikes, and raises a solved or exploded level for the game controller and display logic. It sits directly downstream of the debouncer and upstream of the round/score FSM.

## Interface
- MAX_STRIKES, 3: strike count that forces EXPLODED; legal range 1..3.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- arm  in  1  one-cycle pulse: load the secret and start a round.
- wire_lvl  in  6  debounced wire levels; 1 = intact, 0 = cut.
- cut_order  in  18  secret order, 6 slots × 3-bit wire index; slot k = bits [3k+2:3k]; sampled only on arm.
- cut_len  in  3  number of valid slots; sampled only on arm.
- step_ok  out  1  one-cycle pulse: correct wire cut.
- strike  out  1  one-cycle pulse: wrong cut.
- strike_cnt  out  2  strikes this round, saturating.
- solved  out  1  level: all steps done.
- exploded  out  1  level: strike limit reached.
- step_idx  out  3  index of the next expected slot.

## Operation
- States: IDLE, ACTIVE, SOLVED, EXPLODED.
- prev_lvl register: tracks wire_lvl every cycle in every state.
- Cut event vector: cut = prev_lvl & ~wire_lvl. A 0→1 reconnection is never an event. Cutting a reconnected wire again is an event.
- arm, in any state:
  - latch cut_order and cut_len; clamp cut_len 0→1 and 7→6.
  - clear step_idx, strike_cnt, solved, exploded.
  - go to ACTIVE.
  - arm has priority: cut events in the arm cycle are discarded.
- ACTIVE, per cycle with cut ≠ 0:
  - Exactly one bit set and its index equals the latched slot[step_idx]: step_ok = 1, step_idx + 1. If the new step_idx equals the latched length, set solved and go to SOLVED.
  - Exactly one bit set, any other index: strike = 1, strike_cnt + 1. This includes slot values 6 or 7, which can never match.
  - Two or more bits set in the same cycle: exactly one strike; step_idx unchanged.
  - If a strike makes strike_cnt == MAX_STRIKES: set exploded and go to EXPLODED.
- ACTIVE with cut == 0: no change.
- IDLE, SOLVED, EXPLODED: cut events are ignored; outputs hold. Only arm or rst leaves these states.
- strike_cnt saturates at 3 and never wraps.
- step_ok and strike are never both high in the same cycle.

## Timing
- rst values: state IDLE; step_ok, strike, solved, exploded = 0; strike_cnt = 0; step_idx = 0; prev_lvl = 6'b111111; latched secret = 0.
- Event latency:
  - wire_lvl bit falls and is sampled at edge N, where prev_lvl holds 1.
  - step_ok or strike is high for exactly the cycle after edge N.
  - solved, exploded, step_idx and strike_cnt update at that same edge.
- State after arm: arm sampled at edge N puts the block in ACTIVE after edge N. The first judgeable cut is sampled at edge N+1.
- Wires already cut when arm arrives:
  - they produce no event, because prev_lvl already holds 0;
  - if such a wire is in the order, the round cannot be solved. The controller is responsible for checking this.
- rst mid-round: all state clears at that edge, and any pulse in flight is dropped.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Correct sequence:
  - stimulus: rst; arm with cut_order slots {2,0,5}, cut_len=3, all wires intact; cut wire 2, then 0, then 5, 10 cycles apart.
  - response: three step_ok pulses, 1 cycle each, 1 cycle after each cut; step_idx 1,2,3; solved=1 after the third; strike never asserted.
- Wrong wire:
  - stimulus: same secret; cut wire 4 first.
  - response: strike pulse, strike_cnt=1, step_idx=0; then cut 2 → step_ok.
- Simultaneous cut:
  - stimulus: wire_lvl goes 111111→111010 in one cycle.
  - response: exactly one strike; strike_cnt increments by 1; step_idx unchanged.
- Explosion:
  - stimulus: MAX_STRIKES=3; three wrong single cuts; then a correct cut.
  - response: exploded=1 after the third strike, state EXPLODED; the later cut gives no pulse and strike_cnt stays 3.
- Reconnect and re-arm:
  - stimulus: cut wire 1 (wrong, strike); reconnect wire 1; cut it again.
  - response: second strike. Then arm in the same cycle as a cut: no pulse, counters cleared, ACTIVE.
- Reset and clamp:
  - stimulus: assert rst in the cycle a cut lands.
  - response: no pulse, all outputs 0.
  - stimulus: arm with cut_len=0, slot0=3; cut wire 3.
  - response: step_ok, then solved.
